// File: rtl/sdrd_pkg.sv
// Shared definitions for the SDRD byte assembler slice.
//   ACC_BA_HI        : {BA13,BA12} value that qualifies an access
//   DEF_RESYNC_CODE  : default ba_lo value that resynchronises the frame
//   DEF_WIDTH        : default bits per assembled word
//   sdrd_state_t     : frame state, IDLE (no bits collected) / SHIFT
package sdrd_pkg;

  localparam logic [1:0] ACC_BA_HI       = 2'b01;
  localparam logic [3:0] DEF_RESYNC_CODE = 4'hF;
  localparam int         DEF_WIDTH       = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sdrd_state_t;

endpackage

// File: rtl/sdrd_byte_assembler_acc_edge_detect.sv
// Qualified-access detector for the SDRD byte assembler.
// Forms the access qualifier from the bus controls, registers it, and emits
// a single-cycle event on its rising edge so that an access lasting many
// cycles is counted exactly once.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sser_n     : serial select, active low
//   ba_hi      : {BA13, BA12}
//   br_w       : access qualifier, 1 = counted
//   acc_evt    : one-cycle pulse on the first cycle of a qualified access
module acc_edge_detect
  import sdrd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sser_n,
  input  logic [1:0] ba_hi,
  input  logic       br_w,
  output logic       acc_evt
);

  logic acc;
  logic acc_d;

  assign acc     = ~sser_n & (ba_hi == ACC_BA_HI) & br_w;
  // Combinational edge: the event is seen on the first clk edge of the access.
  assign acc_evt = acc & ~acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_d <= 1'b0;
    end else begin
      acc_d <= acc;
    end
  end

endmodule

// File: rtl/sdrd_byte_assembler.sv
// SDRD byte assembler.
// Samples the serial-data-read bit once per qualified bus access, assembles
// WIDTH bits into a word and offers it to the CPU side through a holding
// register with a valid/ready handshake. A completed word arriving while the
// holding register is still full (and not being consumed) is dropped and
// flagged by the sticky overrun bit. An access with ba_lo == RESYNC_CODE
// restarts the frame instead of shifting.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sser_n     : serial select, active low
//   ba_hi      : {BA13, BA12}
//   ba_lo      : {BA7, BA6, BA5, BA4}
//   br_w       : access qualifier, 1 = counted
//   sdrd       : serial data bit, valid during a qualified access
//   clr        : synchronous clear of counter, valid and overrun
//   byte_ready : consumer takes the held word this cycle
//   byte_out   : holding register
//   byte_valid : holding register has an unconsumed word
//   overrun    : sticky, a completed word was dropped
//   bit_cnt    : bits collected in the current frame
module sdrd_byte_assembler
  import sdrd_pkg::*;
#(
  parameter int         WIDTH       = DEF_WIDTH,
  parameter bit         MSB_FIRST   = 1'b1,
  parameter logic [3:0] RESYNC_CODE = DEF_RESYNC_CODE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sser_n,
  input  logic [1:0]       ba_hi,
  input  logic [3:0]       ba_lo,
  input  logic             br_w,
  input  logic             sdrd,
  input  logic             clr,
  input  logic             byte_ready,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid,
  output logic             overrun,
  output logic [3:0]       bit_cnt
);

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  logic acc_evt;

  acc_edge_detect u_acc_edge_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .sser_n  (sser_n),
    .ba_hi   (ba_hi),
    .br_w    (br_w),
    .acc_evt (acc_evt)
  );

  sdrd_state_t      state_q,    state_d;
  logic [3:0]       bit_cnt_q,  bit_cnt_d;
  logic [WIDTH-1:0] sr_q,       sr_d;
  logic [WIDTH-1:0] hold_q,     hold_d;
  logic             valid_q,    valid_d;
  logic             ovr_q,      ovr_d;

  logic             resync_evt;
  logic             data_evt;
  logic             complete;
  logic [WIDTH-1:0] sr_shift;

  assign resync_evt = acc_evt & (ba_lo == RESYNC_CODE);
  assign data_evt   = acc_evt & (ba_lo != RESYNC_CODE);
  assign complete   = data_evt & (bit_cnt_q == LAST_BIT);
  // The word offered on completion already includes the bit sampled this edge.
  assign sr_shift   = MSB_FIRST ? {sr_q[WIDTH-2:0], sdrd} : {sdrd, sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    if (clr) begin
      // clr overrides events and the handshake; the held word itself is kept.
      state_d   = IDLE;
      bit_cnt_d = '0;
      sr_d      = '0;
      valid_d   = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      if (resync_evt) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        sr_d      = '0;
      end else if (data_evt) begin
        sr_d = sr_shift;
        if (complete) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          state_d   = SHIFT;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      if (complete) begin
        // A consume on the same edge frees the register, so no overrun.
        if (!valid_q || byte_ready) begin
          hold_d  = sr_shift;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else if (valid_q && byte_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  assign byte_out   = hold_q;
  assign byte_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_sdrd_byte_assembler.sv
// Testbench for sdrd_byte_assembler (WIDTH=8, MSB_FIRST=1, RESYNC_CODE=F).
// A queue-based reference model tracks collected bits and the holding
// register; a compare process checks every output on every falling edge.
// Directed scenarios add literal expectations, then randomized traffic runs.
module tb_sdrd_byte_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sser_n = 1'b1;
  logic [1:0] ba_hi = 2'b00;
  logic [3:0] ba_lo = 4'h0;
  logic       br_w = 1'b0;
  logic       sdrd = 1'b0;
  logic       clr = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       overrun;
  logic [3:0] bit_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  sdrd_byte_assembler #(
    .WIDTH       (8),
    .MSB_FIRST   (1'b1),
    .RESYNC_CODE (4'hF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sser_n     (sser_n),
    .ba_hi      (ba_hi),
    .ba_lo      (ba_lo),
    .br_w       (br_w),
    .sdrd       (sdrd),
    .clr        (clr),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .overrun    (overrun),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit       m_bits[$];
  bit       m_prev_acc = 1'b0;
  bit [7:0] m_hold = 8'h00;
  bit       m_valid = 1'b0;
  bit       m_ovr = 1'b0;

  function automatic bit [7:0] assemble();
    bit [7:0] w = 8'h00;
    // First sampled bit is the most significant.
    for (int i = 0; i < 8; i++) w[7-i] = m_bits[i];
    return w;
  endfunction

  task automatic model_step();
    bit acc;
    bit evt;
    bit done;
    bit [7:0] w;
    if (!rst_n) begin
      m_bits.delete();
      m_prev_acc = 1'b0;
      m_hold     = 8'h00;
      m_valid    = 1'b0;
      m_ovr      = 1'b0;
      return;
    end
    acc  = !sser_n && ba_hi == 2'b01 && br_w;
    evt  = acc && !m_prev_acc;
    m_prev_acc = acc;
    done = 1'b0;
    if (clr) begin
      m_bits.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      return;
    end
    if (evt) begin
      if (ba_lo == 4'hF) begin
        m_bits.delete();
      end else begin
        m_bits.push_back(sdrd);
        if (m_bits.size() == 8) begin
          done = 1'b1;
          w = assemble();
          m_bits.delete();
          if (!m_valid || byte_ready) begin
            m_hold  = w;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
    if (!done && m_valid && byte_ready) m_valid = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("model_byte_out", 32'(byte_out), 32'(m_hold));
    check("model_byte_valid", 32'(byte_valid), 32'(m_valid));
    check("model_overrun", 32'(overrun), 32'(m_ovr));
    check("model_bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_bus();
    sser_n = 1'b1; ba_hi = 2'b00; br_w = 1'b0; byte_ready = 1'b0;
  endtask

  // One access of 'hold' cycles, then one idle cycle so the next access
  // produces a fresh rising edge.
  task automatic access(input logic b, input logic [3:0] lo, input int hold, input logic rdy);
    sser_n = 1'b0; ba_hi = 2'b01; br_w = 1'b1; ba_lo = lo; sdrd = b; byte_ready = rdy;
    @(posedge clk); #1;
    byte_ready = 1'b0;
    repeat (hold - 1) begin @(posedge clk); #1; end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy_on_last);
    for (int i = 7; i >= 0; i--) access(b[i], 4'h0, 1, (i == 0) ? rdy_on_last : 1'b0);
  endtask

  task automatic ready_pulse();
    byte_ready = 1'b1; @(posedge clk); #1; byte_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic raw_access(input logic s, input logic [1:0] hi, input logic bw);
    sser_n = s; ba_hi = hi; br_w = bw; ba_lo = 4'h0; sdrd = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
  endtask

  // ---------------- directed + random ----------------
  initial begin
    logic [7:0] pat;
    pat = 8'hB2;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_byte_out", 32'(byte_out), 32'h0);
    check("reset_valid", 32'(byte_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_bit_cnt", 32'(bit_cnt), 32'h0);
    @(posedge clk); #1;

    // 1,0,1,1,0,0,1,0 -> B2
    for (int i = 7; i >= 0; i--) access(pat[i], 4'h0, 1, 1'b0);
    check("b2_byte_out", 32'(byte_out), 32'hB2);
    check("b2_valid", 32'(byte_valid), 32'h1);
    check("b2_bit_cnt", 32'(bit_cnt), 32'h0);
    ready_pulse();
    check("b2_consumed", 32'(byte_valid), 32'h0);

    // Long access counts once
    access(1'b1, 4'h0, 5, 1'b0);
    check("long_access_cnt", 32'(bit_cnt), 32'h1);

    // Non-qualified accesses
    raw_access(1'b0, 2'b11, 1'b1);
    raw_access(1'b1, 2'b01, 1'b1);
    raw_access(1'b0, 2'b01, 1'b0);
    check("unqualified_cnt", 32'(bit_cnt), 32'h1);
    clr_pulse();

    // Partial frame then resync
    access(1'b1, 4'h0, 1, 1'b0);
    access(1'b1, 4'h0, 1, 1'b0);
    access(1'b0, 4'h0, 1, 1'b0);
    access(1'b1, 4'hF, 1, 1'b0);
    check("resync_cnt", 32'(bit_cnt), 32'h0);
    send_byte(8'h5A, 1'b0);
    check("resync_byte_out", 32'(byte_out), 32'h5A);
    check("resync_valid", 32'(byte_valid), 32'h1);
    ready_pulse();

    // Overrun
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("ovr_byte_out", 32'(byte_out), 32'h11);
    check("ovr_flag", 32'(overrun), 32'h1);
    ready_pulse();
    check("ovr_consumed", 32'(byte_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    clr_pulse();
    check("ovr_cleared", 32'(overrun), 32'h0);
    check("clr_keeps_byte", 32'(byte_out), 32'h11);

    // Consume and fill on the same edge
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    check("cf_byte_out", 32'(byte_out), 32'h22);
    check("cf_valid", 32'(byte_valid), 32'h1);
    check("cf_overrun", 32'(overrun), 32'h0);
    ready_pulse();

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) access(1'b1, 4'h0, 1, 1'b0);
    check("prereset_cnt", 32'(bit_cnt), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(bit_cnt), 32'h0);
    check("async_rst_byte", 32'(byte_out), 32'h0);
    check("async_rst_valid", 32'(byte_valid), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'hA5, 1'b0);
    check("post_rst_byte", 32'(byte_out), 32'hA5);
    check("post_rst_valid", 32'(byte_valid), 32'h1);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      sser_n     = ($urandom_range(0, 2) == 0);
      ba_hi      = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b01;
      br_w       = ($urandom_range(0, 5) != 0);
      ba_lo      = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      sdrd       = 1'($urandom);
      byte_ready = ($urandom_range(0, 3) == 0);
      clr        = ($urandom_range(0, 60) == 0);
      @(posedge clk); #1;
    end
    idle_bus();
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
